// File: rtl/game_pkg.sv
// game_pkg
// Shared definitions for the falling-note game blocks.
//   LANE_W      : width of one note pattern (bit0 red ... bit3 yellow)
//   LFSR_TAPS   : Galois feedback mask of the 16-bit pattern generator
//   seq_state_t : note_sequencer FSM encoding
//   lfsr_next   : one Galois step (shift right, XOR taps on shifted-out 1)
//   random_raw  : raw pattern from LFSR state, never zero
//   cap_notes   : density cap, keeps the lowest (level+1) set lanes
package game_pkg;

  localparam int          LANE_W    = 4;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // An all-zero nibble would be an empty row; substitute a single lane
  // chosen by the next two LFSR bits so random rows always carry a note.
  function automatic logic [LANE_W-1:0] random_raw(input logic [15:0] s);
    if (s[3:0] == 4'h0) random_raw = 4'b0001 << s[5:4];
    else                random_raw = s[3:0];
  endfunction

  function automatic logic [LANE_W-1:0] cap_notes(input logic [LANE_W-1:0] pattern,
                                                  input logic [1:0]        level);
    logic [2:0] seen;
    cap_notes = '0;
    seen      = 3'd0;
    for (int b = 0; b < LANE_W; b++) begin
      if (pattern[b] && (seen <= {1'b0, level})) begin
        cap_notes[b] = 1'b1;
        seen         = seen + 3'd1;
      end
    end
  endfunction

endpackage

// File: rtl/note_chart_rom.sv
// note_chart_rom
// Song chart storage: synchronous ROM, one-cycle read latency.
// The table below is the chart.mif content compiled in, so it maps onto
// block/LUT ROM without a memory initialisation file at synthesis time.
//   CLOCK_25 : clock
//   addr     : entry index
//   data     : pattern at addr, valid the cycle after addr is presented
module note_chart_rom #(
  parameter int CHART_LEN = 64,
  parameter int AW        = $clog2(CHART_LEN)
) (
  input  logic          CLOCK_25,
  input  logic [AW-1:0] addr,
  output logic [3:0]    data
);

  function automatic logic [3:0] chart_entry(input logic [5:0] a);
    case (a)
      6'd0:    chart_entry = 4'h1;
      6'd1:    chart_entry = 4'h2;
      6'd2:    chart_entry = 4'h4;
      6'd3:    chart_entry = 4'h8;
      6'd4:    chart_entry = 4'h3;
      6'd5:    chart_entry = 4'h6;
      6'd6:    chart_entry = 4'hC;
      6'd7:    chart_entry = 4'h9;
      default: chart_entry = a[3:0] ^ {a[5:4], 2'b01};
    endcase
  endfunction

  always_ff @(posedge CLOCK_25) begin
    data <= chart_entry(6'(addr));
  end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer
// Feeds the next pattern to each falling-note instance (slot). A slot's
// trocar pulse on req marks it pending; the sequencer refills it from the
// chart ROM or the LFSR (density-capped by level), one refill at a time.
//   CLOCK_25, reset : clock, synchronous active-high reset
//   start           : pulse, (re)starts a song and primes every slot
//   mode, level     : source select (0 chart, 1 random) and difficulty, taken on start
//   req             : per-slot refill request pulses
//   command_out     : slot i pattern at [4i+3:4i]
//   song_done       : chart exhausted
//   busy            : a refill is pending or in flight
//   note_count      : patterns issued since start, saturating
//   dbg_state       : FSM state (seq_state_t encoding)
module note_sequencer
  import game_pkg::*;
#(
  parameter int          N_SLOTS   = 4,
  parameter int          CHART_LEN = 64,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      CLOCK_25,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      mode,
  input  logic [1:0]                level,
  input  logic [N_SLOTS-1:0]        req,
  output logic [LANE_W*N_SLOTS-1:0] command_out,
  output logic                      song_done,
  output logic                      busy,
  output logic [7:0]                note_count,
  output logic [1:0]                dbg_state
);

  localparam int AW = $clog2(CHART_LEN);
  localparam int PW = $clog2(CHART_LEN + 1);
  localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  seq_state_t         state;
  logic               mode_r;
  logic [1:0]         level_r;
  logic [N_SLOTS-1:0] pending;
  logic [15:0]        lfsr;
  logic [PW-1:0]      ptr;
  logic               w_valid;
  logic [SW-1:0]      w_slot;
  logic [3:0]         rom_data;

  // Handshake: req[i] is a fire-and-forget pulse; its acceptance is the
  // pending[i] bit. pending[i] stays set until the cycle slot i's register
  // is written (stage W). A req landing on that same cycle re-arms the bit,
  // and a req while already pending merges into it.

  logic               sel_found;
  logic [SW-1:0]      sel_idx;
  logic               s_fire;
  logic [N_SLOTS-1:0] clr_mask;
  logic [N_SLOTS-1:0] pending_nxt;
  logic               ptr_inc;
  logic               done_nxt;
  logic [3:0]         w_pattern;

  note_chart_rom #(.CHART_LEN(CHART_LEN), .AW(AW)) u_rom (
    .CLOCK_25 (CLOCK_25),
    .addr     (ptr[AW-1:0]),
    .data     (rom_data)
  );

  // Lowest-index pending slot wins (scan high to low, last hit sticks).
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_found = 1'b1;
        sel_idx   = SW'(i);
      end
    end
  end

  always_comb begin
    s_fire   = (state != IDLE) && sel_found && !w_valid;
    clr_mask = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      clr_mask[i] = w_valid && (w_slot == SW'(i));
    end
    pending_nxt = (pending & ~clr_mask) | ((state != IDLE) ? req : '0);
    ptr_inc     = w_valid && !mode_r && (ptr != PW'(CHART_LEN));
    done_nxt    = song_done || (ptr_inc && ((ptr + PW'(1)) == PW'(CHART_LEN)));
    // The ROM was read at this same ptr during stage S; ptr only moves in W.
    if (state == DONE)                 w_pattern = 4'b0000;
    else if (mode_r)                   w_pattern = cap_notes(random_raw(lfsr), level_r);
    else if (ptr == PW'(CHART_LEN))    w_pattern = 4'b0000;
    else                               w_pattern = rom_data;
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state       <= IDLE;
      mode_r      <= 1'b0;
      level_r     <= 2'd0;
      pending     <= '0;
      lfsr        <= LFSR_SEED;
      ptr         <= '0;
      w_valid     <= 1'b0;
      w_slot      <= '0;
      command_out <= '0;
      song_done   <= 1'b0;
      note_count  <= 8'd0;
    end else if (start) begin
      // Restart from any state; an in-flight refill is dropped.
      state      <= PRIME;
      mode_r     <= mode;
      level_r    <= level;
      pending    <= '1;
      lfsr       <= LFSR_SEED;
      ptr        <= '0;
      w_valid    <= 1'b0;
      song_done  <= 1'b0;
      note_count <= 8'd0;
    end else begin
      pending   <= pending_nxt;
      w_valid   <= s_fire;
      song_done <= done_nxt;
      if (s_fire) begin
        w_slot <= sel_idx;
        if (mode_r) lfsr <= lfsr_next(lfsr);
      end
      if (w_valid) begin
        for (int i = 0; i < N_SLOTS; i++) begin
          if (w_slot == SW'(i)) command_out[i*LANE_W +: LANE_W] <= w_pattern;
        end
        if (note_count != 8'hFF) note_count <= note_count + 8'd1;
      end
      if (ptr_inc) ptr <= ptr + PW'(1);
      case (state)
        PRIME:   if (pending_nxt == '0 && !s_fire) state <= RUN;
        RUN:     if (done_nxt && pending_nxt == '0 && !s_fire) state <= DONE;
        default: state <= state;
      endcase
    end
  end

  assign busy      = (pending != '0) || w_valid;
  assign dbg_state = state;

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;
  import game_pkg::*;

  logic        CLOCK_25;
  logic        reset;
  logic        start;
  logic        mode;
  logic [1:0]  level;
  logic [3:0]  req;
  logic [15:0] command_out;
  logic        song_done;
  logic        busy;
  logic [7:0]  note_count;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // {slot, pattern}
  logic [7:0] exp_q[$];

  logic [3:0] chart_tab [0:7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'h9};

  note_sequencer #(.N_SLOTS(4), .CHART_LEN(8), .LFSR_SEED(16'hACE1)) dut (
    .CLOCK_25    (CLOCK_25),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .level       (level),
    .req         (req),
    .command_out (command_out),
    .song_done   (song_done),
    .busy        (busy),
    .note_count  (note_count),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    CLOCK_25 = 1'b0;
    forever #20 CLOCK_25 = ~CLOCK_25;
  end

  task automatic tick();
    @(posedge CLOCK_25);
    #1;
  endtask

  // reference model of the random source
  function automatic logic [15:0] m_step(input logic [15:0] s);
    m_step = (s >> 1) ^ ({16{s[0]}} & 16'hB400);
  endfunction

  function automatic logic [3:0] m_raw(input logic [15:0] s);
    m_raw = (s[3:0] != 4'h0) ? s[3:0] : (4'd1 << s[5:4]);
  endfunction

  function automatic logic [3:0] m_cap(input logic [3:0] p, input int lvl);
    logic [3:0] rest, lo;
    m_cap = 4'h0;
    rest  = p;
    for (int k = 0; k <= lvl; k++) begin
      lo    = rest & (~rest + 4'd1);
      m_cap = m_cap | lo;
      rest  = rest & ~lo;
    end
  endfunction

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // driver tasks / scenarios
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 1'b0; level = 2'd0; req = 4'h0;
    tick(); tick();
    n_checks++; if (command_out !== 16'h0) begin n_fail++; $display("FAIL reset_cmd: got %h want 0000", command_out); end
    n_checks++; if (note_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", note_count); end
    n_checks++; if (busy !== 1'b0 || song_done !== 1'b0) begin n_fail++; $display("FAIL reset_flags: busy %b done %b want 0 0", busy, song_done); end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    reset = 1'b0;
    req = 4'hF; tick(); req = 4'h0; tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_ignores_req: busy %b want 0", busy); end
  endtask

  task automatic test_prime_chart();
    logic [7:0] e;
    logic [3:0] got;
    start = 1'b1; mode = 1'b0; level = 2'd0; tick(); start = 1'b0;
    for (int s = 0; s < 4; s++) exp_q.push_back({4'(s), chart_tab[s]});
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k % 2 == 0) begin
        e = exp_q.pop_front();
        got = command_out[e[7:4]*4 +: 4];
        n_checks++; if (got !== e[3:0]) begin n_fail++; $display("FAIL prime_slot%0d: got %h want %h", e[7:4], got, e[3:0]); end
      end
    end
    n_checks++; if (command_out !== 16'h8421) begin n_fail++; $display("FAIL prime_cmd: got %h want 8421", command_out); end
    n_checks++; if (note_count !== 8'd4) begin n_fail++; $display("FAIL prime_count: got %0d want 4", note_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prime_busy: got %b want 0", busy); end
    n_checks++; if (dbg_state !== RUN) begin n_fail++; $display("FAIL prime_state: got %0d want %0d", dbg_state, RUN); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] e;
    req = 4'b1010; tick(); req = 4'h0;
    exp_q.push_back({4'd1, chart_tab[4]});
    exp_q.push_back({4'd3, chart_tab[5]});
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sim_busy: got %b want 1", busy); end
    tick();
    n_checks++; if (command_out[7:4] !== 4'h2) begin n_fail++; $display("FAIL sim_early_write: slot1 %h want 2", command_out[7:4]); end
    tick();
    e = exp_q.pop_front();
    n_checks++; if (command_out[7:4] !== e[3:0]) begin n_fail++; $display("FAIL sim_slot1: got %h want %h", command_out[7:4], e[3:0]); end
    n_checks++; if (command_out[15:12] !== 4'h8) begin n_fail++; $display("FAIL sim_slot3_early: got %h want 8", command_out[15:12]); end
    tick(); tick();
    e = exp_q.pop_front();
    n_checks++; if (command_out[15:12] !== e[3:0]) begin n_fail++; $display("FAIL sim_slot3: got %h want %h", command_out[15:12], e[3:0]); end
    n_checks++; if (note_count !== 8'd6 || busy !== 1'b0) begin n_fail++; $display("FAIL sim_end: count %0d busy %b want 6 0", note_count, busy); end
  endtask

  task automatic test_set_beats_clear();
    logic [7:0] e;
    req = 4'b0001; tick(); req = 4'h0;
    exp_q.push_back({4'd0, chart_tab[6]});
    exp_q.push_back({4'd0, chart_tab[7]});
    tick();
    req = 4'b0001; tick(); req = 4'h0;
    e = exp_q.pop_front();
    n_checks++; if (command_out[3:0] !== e[3:0]) begin n_fail++; $display("FAIL sbc_first: got %h want %h", command_out[3:0], e[3:0]); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sbc_rearmed: busy %b want 1", busy); end
    n_checks++; if (song_done !== 1'b0) begin n_fail++; $display("FAIL sbc_done_early: got %b want 0", song_done); end
    tick(); tick();
    e = exp_q.pop_front();
    n_checks++; if (command_out[3:0] !== e[3:0]) begin n_fail++; $display("FAIL sbc_second: got %h want %h", command_out[3:0], e[3:0]); end
    n_checks++; if (note_count !== 8'd8 || busy !== 1'b0) begin n_fail++; $display("FAIL sbc_count: count %0d busy %b want 8 0", note_count, busy); end
    n_checks++; if (song_done !== 1'b1) begin n_fail++; $display("FAIL chart_done: got %b want 1", song_done); end
    n_checks++; if (dbg_state !== DONE) begin n_fail++; $display("FAIL chart_done_state: got %0d want %0d", dbg_state, DONE); end
  endtask

  task automatic test_chart_end_merge();
    // second req arrives while slot2 is pending: one refill only
    req = 4'b0100; tick(); tick(); req = 4'h0; tick();
    n_checks++; if (command_out !== 16'h6039) begin n_fail++; $display("FAIL end_cmd: got %h want 6039", command_out); end
    n_checks++; if (note_count !== 8'd9 || busy !== 1'b0) begin n_fail++; $display("FAIL end_merge: count %0d busy %b want 9 0", note_count, busy); end
    n_checks++; if (dbg_state !== DONE || song_done !== 1'b1) begin n_fail++; $display("FAIL end_state: state %0d done %b want %0d 1", dbg_state, song_done, DONE); end
  endtask

  task automatic test_random(input int lvl, input int count);
    logic [15:0] m;
    logic [7:0]  e;
    logic [3:0]  got, pat;
    bit          ok;
    bit          found;
    int          slot;
    int          n;
    start = 1'b1; mode = 1'b1; level = 2'(lvl); tick(); start = 1'b0;
    // inputs are sampled only on start
    mode = 1'b0; level = 2'(3 - lvl);
    n_checks++; if (dbg_state !== PRIME || note_count !== 8'd0 || song_done !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_restart: state %0d count %0d done %b", lvl, dbg_state, note_count, song_done); end
    m = 16'hACE1;
    for (int s = 0; s < 4; s++) begin
      m = m_step(m);
      exp_q.push_back({4'(s), m_cap(m_raw(m), lvl)});
    end
    for (int k = 0; k < 8; k++) tick();
    for (int s = 0; s < 4; s++) begin
      e = exp_q.pop_front();
      got = command_out[e[7:4]*4 +: 4];
      n_checks++; if (got !== e[3:0]) begin n_fail++; $display("FAIL rnd%0d_prime_slot%0d: got %h want %h", lvl, e[7:4], got, e[3:0]); end
    end
    n_checks++; if (dbg_state !== RUN) begin n_fail++; $display("FAIL rnd%0d_run: state %0d want %0d", lvl, dbg_state, RUN); end
    found = 1'b0;
    n = 0;
    while (n < count && !(lvl == 3 && found)) begin
      slot = $urandom_range(0, 3);
      m = m_step(m);
      exp_q.push_back({4'(slot), m_cap(m_raw(m), lvl)});
      req = 4'b0001 << slot; tick(); req = 4'h0;
      wait_idle(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rnd%0d_timeout: busy %b want 0", lvl, busy); end
      e = exp_q.pop_front();
      got = command_out[e[7:4]*4 +: 4];
      pat = e[3:0];
      n_checks++; if (got !== pat) begin n_fail++; $display("FAIL rnd%0d_refill%0d: slot %0d got %h want %h", lvl, n, e[7:4], got, pat); end
      if (lvl == 0) begin
        n_checks++; if (got == 4'h0 || (got & (got - 4'd1)) != 4'h0) begin n_fail++; $display("FAIL rnd0_onehot: got %b want one-hot", got); end
      end
      if (got == 4'hF) found = 1'b1;
      n++;
    end
    n_checks++; if (song_done !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_done: got %b want 0", lvl, song_done); end
    if (lvl == 3) begin
      n_checks++; if (!found) begin n_fail++; $display("FAIL rnd3_full_row: got none want 1111 within %0d", count); end
    end
  endtask

  task automatic test_reset_mid_serve();
    req = 4'b0001; tick(); req = 4'h0;
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_inflight: busy %b want 1", busy); end
    reset = 1'b1; tick();
    n_checks++; if (command_out !== 16'h0 || note_count !== 8'd0) begin n_fail++; $display("FAIL mid_reset_out: cmd %h count %0d want 0 0", command_out, note_count); end
    n_checks++; if (busy !== 1'b0 || song_done !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL mid_reset_flags: busy %b done %b state %0d", busy, song_done, dbg_state); end
    reset = 1'b0; tick(); tick();
    n_checks++; if (command_out !== 16'h0 || note_count !== 8'd0) begin n_fail++; $display("FAIL mid_no_write: cmd %h count %0d want 0 0", command_out, note_count); end
  endtask

  initial begin
    test_reset();
    test_prime_chart();
    test_simultaneous();
    test_set_beats_clear();
    test_chart_end_merge();
    test_random(0, 200);
    test_random(1, 40);
    test_random(3, 2000);
    test_reset_mid_serve();
    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
